// File: rtl/bp_stream_host_axil.sv
// Host-side consumer of the BlackParrot I/O command stream: address/data word pairs become AXI4-Lite transactions.
// Define BP_STREAM_HOST_AXIL_TIMEOUT_EN to add a watchdog on the B and R waits.
module bp_stream_host_axil #(
    parameter int stream_data_width_p = 32,
    parameter int axil_addr_width_p   = 32,
    parameter int read_flag_bit_p     = 31,
    parameter int resp_words_p        = 2,
    parameter int timeout_cycles_p    = 1024
) (
    input  logic                             clk_i,
    input  logic                             reset_n_i,

    input  logic                             stream_v_i,
    input  logic [stream_data_width_p-1:0]   stream_data_i,
    output logic                             stream_ready_o,

    output logic                             stream_v_o,
    output logic [stream_data_width_p-1:0]   stream_data_o,
    input  logic                             stream_yumi_i,

    output logic [axil_addr_width_p-1:0]     m_axil_awaddr_o,
    output logic [2:0]                       m_axil_awprot_o,
    output logic                             m_axil_awvalid_o,
    input  logic                             m_axil_awready_i,

    output logic [stream_data_width_p-1:0]   m_axil_wdata_o,
    output logic [stream_data_width_p/8-1:0] m_axil_wstrb_o,
    output logic                             m_axil_wvalid_o,
    input  logic                             m_axil_wready_i,

    input  logic [1:0]                       m_axil_bresp_i,
    input  logic                             m_axil_bvalid_i,
    output logic                             m_axil_bready_o,

    output logic [axil_addr_width_p-1:0]     m_axil_araddr_o,
    output logic [2:0]                       m_axil_arprot_o,
    output logic                             m_axil_arvalid_o,
    input  logic                             m_axil_arready_i,

    input  logic [stream_data_width_p-1:0]   m_axil_rdata_i,
    input  logic [1:0]                       m_axil_rresp_i,
    input  logic                             m_axil_rvalid_i,
    output logic                             m_axil_rready_o,

    output logic                             error_o
);

    localparam int beat_width_lp = (resp_words_p > 1) ? $clog2(resp_words_p) : 1;

    typedef enum logic [2:0] {e_addr, e_data, e_aw, e_b, e_ar, e_r} state_e;

    state_e                           state_r;
    logic [axil_addr_width_p-1:0]     addr_r;
    logic [stream_data_width_p-1:0]   data_r;
    logic                             is_rd_r;
    logic                             aw_done_r;
    logic                             w_done_r;
    logic [beat_width_lp-1:0]         beat_r;
    logic                             stream_ready_r;
    logic                             awvalid_r;
    logic                             wvalid_r;
    logic                             bready_r;
    logic                             arvalid_r;
    logic                             error_r;

    logic [stream_data_width_p-1:0]   addr_word;
    logic                             stream_hs;
    logic                             aw_hs;
    logic                             w_hs;
    logic                             b_hs;
    logic                             ar_hs;
    logic                             r_hs;
    logic                             last_beat;
    logic                             timed_out;

    logic [stream_data_width_p-1:0]   fifo_mem_r [2];
    logic                             fifo_wptr_r;
    logic                             fifo_rptr_r;
    logic [1:0]                       fifo_count_r;
    logic                             fifo_push;
    logic                             fifo_pop;
    logic                             fifo_full;
    logic [stream_data_width_p-1:0]   fifo_wdata;

    always_comb begin
        addr_word                  = stream_data_i;
        addr_word[read_flag_bit_p] = 1'b0;
    end

    assign stream_hs = stream_v_i && stream_ready_r;
    assign aw_hs     = awvalid_r && m_axil_awready_i;
    assign w_hs      = wvalid_r && m_axil_wready_i;
    assign b_hs      = bready_r && m_axil_bvalid_i;
    assign ar_hs     = arvalid_r && m_axil_arready_i;
    assign r_hs      = m_axil_rready_o && m_axil_rvalid_i;
    assign last_beat = (beat_r == beat_width_lp'(resp_words_p - 1));

    assign stream_ready_o   = stream_ready_r;
    assign m_axil_awaddr_o  = addr_r;
    assign m_axil_awprot_o  = 3'b000;
    assign m_axil_awvalid_o = awvalid_r;
    assign m_axil_wdata_o   = data_r;
    assign m_axil_wstrb_o   = '1;
    assign m_axil_wvalid_o  = wvalid_r;
    assign m_axil_bready_o  = bready_r;
    assign m_axil_araddr_o  = addr_r + (axil_addr_width_p'(beat_r) << 2);
    assign m_axil_arprot_o  = 3'b000;
    assign m_axil_arvalid_o = arvalid_r;
    assign m_axil_rready_o  = (state_r == e_r) && !fifo_full && !timed_out;
    assign error_o          = error_r;

    // A timed-out read fills its missing beats with a marker word instead of R data.
    always_comb begin
        fifo_push  = r_hs;
        fifo_wdata = m_axil_rdata_i;
        if ((state_r == e_r) && timed_out && !fifo_full) begin
            fifo_push  = 1'b1;
            fifo_wdata = stream_data_width_p'(32'hDEAD_BEEF);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r        <= e_addr;
            addr_r         <= '0;
            data_r         <= '0;
            is_rd_r        <= 1'b0;
            aw_done_r      <= 1'b0;
            w_done_r       <= 1'b0;
            beat_r         <= '0;
            stream_ready_r <= 1'b0;
            awvalid_r      <= 1'b0;
            wvalid_r       <= 1'b0;
            bready_r       <= 1'b0;
            arvalid_r      <= 1'b0;
            error_r        <= 1'b0;
        end else begin
            case (state_r)
                e_addr: begin
                    stream_ready_r <= 1'b1;
                    if (stream_hs) begin
                        addr_r  <= axil_addr_width_p'(addr_word);
                        is_rd_r <= stream_data_i[read_flag_bit_p];
                        state_r <= e_data;
                    end
                end
                e_data: if (stream_hs) begin
                    stream_ready_r <= 1'b0;
                    if (is_rd_r) begin
                        arvalid_r <= 1'b1;
                        state_r   <= e_ar;
                    end else begin
                        data_r    <= stream_data_i;
                        awvalid_r <= 1'b1;
                        wvalid_r  <= 1'b1;
                        state_r   <= e_aw;
                    end
                end
                // AW and W retire independently; B is awaited only once both have.
                e_aw: begin
                    if (aw_hs) begin
                        awvalid_r <= 1'b0;
                        aw_done_r <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid_r <= 1'b0;
                        w_done_r <= 1'b1;
                    end
                    if ((aw_done_r || aw_hs) && (w_done_r || w_hs)) begin
                        aw_done_r <= 1'b0;
                        w_done_r  <= 1'b0;
                        bready_r  <= 1'b1;
                        state_r   <= e_b;
                    end
                end
                e_b: begin
                    if (b_hs) begin
                        if (m_axil_bresp_i != 2'b00) error_r <= 1'b1;
                        bready_r       <= 1'b0;
                        stream_ready_r <= 1'b1;
                        state_r        <= e_addr;
                    end else if (timed_out) begin
                        error_r        <= 1'b1;
                        bready_r       <= 1'b0;
                        stream_ready_r <= 1'b1;
                        state_r        <= e_addr;
                    end
                end
                e_ar: if (ar_hs) begin
                    arvalid_r <= 1'b0;
                    state_r   <= e_r;
                end
                e_r: if (fifo_push) begin
                    if ((r_hs && (m_axil_rresp_i != 2'b00)) || timed_out) error_r <= 1'b1;
                    if (last_beat) begin
                        beat_r         <= '0;
                        stream_ready_r <= 1'b1;
                        state_r        <= e_addr;
                    end else begin
                        beat_r <= beat_r + beat_width_lp'(1);
                        if (!timed_out) begin
                            arvalid_r <= 1'b1;
                            state_r   <= e_ar;
                        end
                    end
                end
                default: state_r <= e_addr;
            endcase
        end
    end

    assign fifo_pop   = stream_v_o && stream_yumi_i;
    assign fifo_full  = (fifo_count_r == 2'd2);
    assign stream_v_o = (fifo_count_r != 2'd0);
    assign stream_data_o = fifo_mem_r[fifo_rptr_r];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            fifo_mem_r[0] <= '0;
            fifo_mem_r[1] <= '0;
            fifo_wptr_r   <= 1'b0;
            fifo_rptr_r   <= 1'b0;
            fifo_count_r  <= 2'd0;
        end else begin
            if (fifo_push) begin
                fifo_mem_r[fifo_wptr_r] <= fifo_wdata;
                fifo_wptr_r             <= ~fifo_wptr_r;
            end
            if (fifo_pop) fifo_rptr_r <= ~fifo_rptr_r;
            fifo_count_r <= fifo_count_r + {1'b0, fifo_push} - {1'b0, fifo_pop};
        end
    end

`ifdef BP_STREAM_HOST_AXIL_TIMEOUT_EN
    localparam int tmo_width_lp = $clog2(timeout_cycles_p + 1);

    logic [tmo_width_lp-1:0] tmo_cnt_r;
    state_e                  tmo_state_r;

    // The count restarts whenever the FSM moves, so each wait is timed on its own.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            tmo_cnt_r   <= '0;
            tmo_state_r <= e_addr;
        end else begin
            tmo_state_r <= state_r;
            if ((state_r != tmo_state_r) || !((state_r == e_b) || (state_r == e_r))) begin
                tmo_cnt_r <= '0;
            end else if (!timed_out) begin
                tmo_cnt_r <= tmo_cnt_r + tmo_width_lp'(1);
            end
        end
    end

    assign timed_out = (tmo_cnt_r == tmo_width_lp'(timeout_cycles_p)) && (state_r == tmo_state_r);
`else
    localparam int unused_timeout_cycles_lp = timeout_cycles_p;

    assign timed_out = 1'b0;
`endif

endmodule

// File: tb/tb_bp_stream_host_axil.sv
// Directed bench for bp_stream_host_axil: write, read, AW/W skew, backpressure, sticky error, async reset.
// With BP_STREAM_HOST_AXIL_TIMEOUT_EN defined it also exercises the R watchdog.
module tb_bp_stream_host_axil;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic        stream_v_i;
    logic [31:0] stream_data_i;
    logic        stream_ready_o;
    logic        stream_v_o;
    logic [31:0] stream_data_o;
    logic        stream_yumi_i;
    logic [31:0] m_axil_awaddr_o;
    logic [2:0]  m_axil_awprot_o;
    logic        m_axil_awvalid_o;
    logic        m_axil_awready_i;
    logic [31:0] m_axil_wdata_o;
    logic [3:0]  m_axil_wstrb_o;
    logic        m_axil_wvalid_o;
    logic        m_axil_wready_i;
    logic [1:0]  m_axil_bresp_i;
    logic        m_axil_bvalid_i;
    logic        m_axil_bready_o;
    logic [31:0] m_axil_araddr_o;
    logic [2:0]  m_axil_arprot_o;
    logic        m_axil_arvalid_o;
    logic        m_axil_arready_i;
    logic [31:0] m_axil_rdata_i;
    logic [1:0]  m_axil_rresp_i;
    logic        m_axil_rvalid_i;
    logic        m_axil_rready_o;
    logic        error_o;

    int assert_cnt = 0;
    int fail_cnt   = 0;
    int aw_cnt     = 0;
    int w_cnt      = 0;
    int b_cnt      = 0;
    int ar_cnt     = 0;
    int pop_cnt    = 0;
    logic [31:0] pop_log [64];

    bp_stream_host_axil dut (
        .clk_i            (clk_i),
        .reset_n_i        (reset_n_i),
        .stream_v_i       (stream_v_i),
        .stream_data_i    (stream_data_i),
        .stream_ready_o   (stream_ready_o),
        .stream_v_o       (stream_v_o),
        .stream_data_o    (stream_data_o),
        .stream_yumi_i    (stream_yumi_i),
        .m_axil_awaddr_o  (m_axil_awaddr_o),
        .m_axil_awprot_o  (m_axil_awprot_o),
        .m_axil_awvalid_o (m_axil_awvalid_o),
        .m_axil_awready_i (m_axil_awready_i),
        .m_axil_wdata_o   (m_axil_wdata_o),
        .m_axil_wstrb_o   (m_axil_wstrb_o),
        .m_axil_wvalid_o  (m_axil_wvalid_o),
        .m_axil_wready_i  (m_axil_wready_i),
        .m_axil_bresp_i   (m_axil_bresp_i),
        .m_axil_bvalid_i  (m_axil_bvalid_i),
        .m_axil_bready_o  (m_axil_bready_o),
        .m_axil_araddr_o  (m_axil_araddr_o),
        .m_axil_arprot_o  (m_axil_arprot_o),
        .m_axil_arvalid_o (m_axil_arvalid_o),
        .m_axil_arready_i (m_axil_arready_i),
        .m_axil_rdata_i   (m_axil_rdata_i),
        .m_axil_rresp_i   (m_axil_rresp_i),
        .m_axil_rvalid_i  (m_axil_rvalid_i),
        .m_axil_rready_o  (m_axil_rready_o),
        .error_o          (error_o)
    );

    always #5 clk_i = ~clk_i;

    // Handshake counters and a log of every response word the consumer takes.
    always @(posedge clk_i) begin
        if (m_axil_awvalid_o && m_axil_awready_i) aw_cnt <= aw_cnt + 1;
        if (m_axil_wvalid_o && m_axil_wready_i)   w_cnt  <= w_cnt + 1;
        if (m_axil_bvalid_i && m_axil_bready_o)   b_cnt  <= b_cnt + 1;
        if (m_axil_arvalid_o && m_axil_arready_i) ar_cnt <= ar_cnt + 1;
        if (stream_v_o && stream_yumi_i && (pop_cnt < 64)) begin
            pop_log[pop_cnt] <= stream_data_o;
            pop_cnt          <= pop_cnt + 1;
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL global_watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assert_cnt++;
        assert (observed === expected) else begin
            fail_cnt++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // which: 0 stream_ready_o, 1 arvalid, 2 rready, 3 response fifo empty
    task automatic waitFor(input int which, input string tag, input int limit);
        int  n;
        logic hit;
        n = 0;
        forever begin
            case (which)
                0:       hit = stream_ready_o;
                1:       hit = m_axil_arvalid_o;
                2:       hit = m_axil_rready_o;
                default: hit = !stream_v_o;
            endcase
            if (hit || (n >= limit)) break;
            tick();
            n++;
        end
        if (!hit) begin
            assert_cnt++;
            fail_cnt++;
            $display("[TB] FAIL wait_%s: observed no event after %0d cycles, expected event", tag, limit);
        end
    endtask

    // Presents one command word and holds it until the DUT accepts it.
    task automatic applyStimulus(input logic [31:0] word);
        stream_v_i    = 1'b1;
        stream_data_i = word;
        waitFor(0, "stream_accept", 50);
        tick();
        stream_v_i = 1'b0;
    endtask

    initial begin
        int base;
        int ar_start;
        int b_start;
        int aw_start;
        int w_start;

        reset_n_i        = 1'b0;
        stream_v_i       = 1'b0;
        stream_data_i    = '0;
        stream_yumi_i    = 1'b0;
        m_axil_awready_i = 1'b0;
        m_axil_wready_i  = 1'b0;
        m_axil_bresp_i   = 2'b00;
        m_axil_bvalid_i  = 1'b0;
        m_axil_arready_i = 1'b1;
        m_axil_rdata_i   = '0;
        m_axil_rresp_i   = 2'b00;
        m_axil_rvalid_i  = 1'b0;

        #12;
        checkOutput("reset_stream_ready", stream_ready_o, 0);
        checkOutput("reset_awvalid", m_axil_awvalid_o, 0);
        checkOutput("reset_wvalid", m_axil_wvalid_o, 0);
        checkOutput("reset_arvalid", m_axil_arvalid_o, 0);
        checkOutput("reset_bready", m_axil_bready_o, 0);
        checkOutput("reset_rready", m_axil_rready_o, 0);
        checkOutput("reset_stream_v", stream_v_o, 0);
        checkOutput("reset_error", error_o, 0);
        checkOutput("reset_awaddr", m_axil_awaddr_o, 0);
        checkOutput("reset_araddr", m_axil_araddr_o, 0);
        checkOutput("reset_wdata", m_axil_wdata_o, 0);
        #5 reset_n_i = 1'b1;
        tick();
        checkOutput("ready_after_reset", stream_ready_o, 1);

        $display("[TB] basic write");
        m_axil_awready_i = 1'b1;
        m_axil_wready_i  = 1'b1;
        applyStimulus(32'h0000_1000);
        applyStimulus(32'h0000_00AB);
        checkOutput("wr_awvalid", m_axil_awvalid_o, 1);
        checkOutput("wr_wvalid", m_axil_wvalid_o, 1);
        checkOutput("wr_awaddr", m_axil_awaddr_o, 32'h0000_1000);
        checkOutput("wr_wdata", m_axil_wdata_o, 32'h0000_00AB);
        checkOutput("wr_wstrb", {28'd0, m_axil_wstrb_o}, 32'hF);
        checkOutput("wr_awprot", {29'd0, m_axil_awprot_o}, 0);
        checkOutput("wr_no_arvalid", m_axil_arvalid_o, 0);
        checkOutput("wr_stream_blocked", stream_ready_o, 0);
        tick();
        checkOutput("wr_bready", m_axil_bready_o, 1);
        checkOutput("wr_aw_dropped", m_axil_awvalid_o, 0);
        m_axil_bvalid_i = 1'b1;
        tick();
        m_axil_bvalid_i = 1'b0;
        checkOutput("wr_bready_low", m_axil_bready_o, 0);
        checkOutput("wr_back_to_addr", stream_ready_o, 1);
        checkOutput("wr_no_stream_v", stream_v_o, 0);
        checkOutput("wr_b_count", b_cnt, 1);
        checkOutput("wr_aw_count", aw_cnt, 1);

        $display("[TB] basic read");
        applyStimulus(32'h8000_2000);
        applyStimulus(32'h0000_0000);
        checkOutput("rd_arvalid", m_axil_arvalid_o, 1);
        checkOutput("rd_araddr0", m_axil_araddr_o, 32'h0000_2000);
        checkOutput("rd_arprot", {29'd0, m_axil_arprot_o}, 0);
        checkOutput("rd_no_awvalid", m_axil_awvalid_o, 0);
        tick();
        checkOutput("rd_rready", m_axil_rready_o, 1);
        m_axil_rdata_i  = 32'h1111_1111;
        m_axil_rvalid_i = 1'b1;
        tick();
        m_axil_rvalid_i = 1'b0;
        checkOutput("rd_araddr1", m_axil_araddr_o, 32'h0000_2004);
        checkOutput("rd_stream_v", stream_v_o, 1);
        checkOutput("rd_stream_data0", stream_data_o, 32'h1111_1111);
        tick();
        m_axil_rdata_i  = 32'h2222_2222;
        m_axil_rvalid_i = 1'b1;
        tick();
        m_axil_rvalid_i = 1'b0;
        checkOutput("rd_back_to_addr", stream_ready_o, 1);
        checkOutput("rd_ar_count", ar_cnt, 2);
        base = pop_cnt;
        stream_yumi_i = 1'b1;
        tick();
        tick();
        stream_yumi_i = 1'b0;
        checkOutput("rd_drained", stream_v_o, 0);
        checkOutput("rd_pop_count", pop_cnt - base, 2);
        checkOutput("rd_word0", pop_log[base], 32'h1111_1111);
        checkOutput("rd_word1", pop_log[base + 1], 32'h2222_2222);

        $display("[TB] AW/W skew");
        m_axil_awready_i = 1'b1;
        m_axil_wready_i  = 1'b0;
        b_start  = b_cnt;
        aw_start = aw_cnt;
        w_start  = w_cnt;
        applyStimulus(32'h0000_5000);
        applyStimulus(32'h0000_0077);
        tick();
        checkOutput("skew_aw_done", m_axil_awvalid_o, 0);
        checkOutput("skew_w_held1", m_axil_wvalid_o, 1);
        tick();
        tick();
        tick();
        checkOutput("skew_w_held4", m_axil_wvalid_o, 1);
        checkOutput("skew_no_bready", m_axil_bready_o, 0);
        m_axil_wready_i = 1'b1;
        tick();
        checkOutput("skew_w_done", m_axil_wvalid_o, 0);
        checkOutput("skew_bready", m_axil_bready_o, 1);
        checkOutput("skew_wdata", m_axil_wdata_o, 32'h0000_0077);
        m_axil_bvalid_i = 1'b1;
        tick();
        m_axil_bvalid_i = 1'b0;
        tick();
        tick();
        checkOutput("skew_one_b", b_cnt - b_start, 1);
        checkOutput("skew_one_aw", aw_cnt - aw_start, 1);
        checkOutput("skew_one_w", w_cnt - w_start, 1);

        $display("[TB] sticky error");
        applyStimulus(32'h0000_6000);
        applyStimulus(32'h0000_0001);
        tick();
        checkOutput("err_before_b", error_o, 0);
        m_axil_bresp_i  = 2'b10;
        m_axil_bvalid_i = 1'b1;
        tick();
        m_axil_bvalid_i = 1'b0;
        m_axil_bresp_i  = 2'b00;
        checkOutput("err_rise", error_o, 1);
        applyStimulus(32'h0000_6004);
        applyStimulus(32'h0000_0002);
        tick();
        m_axil_bvalid_i = 1'b1;
        tick();
        m_axil_bvalid_i = 1'b0;
        checkOutput("err_sticky_write", error_o, 1);

        $display("[TB] response backpressure");
        ar_start = ar_cnt;
        applyStimulus(32'h8000_3000);
        applyStimulus(32'h0000_0000);
        tick();
        m_axil_rdata_i  = 32'h3333_0000;
        m_axil_rvalid_i = 1'b1;
        tick();
        m_axil_rvalid_i = 1'b0;
        tick();
        m_axil_rdata_i  = 32'h3333_0004;
        m_axil_rvalid_i = 1'b1;
        tick();
        m_axil_rvalid_i = 1'b0;
        applyStimulus(32'h8000_4000);
        applyStimulus(32'h0000_0000);
        checkOutput("bp_araddr0", m_axil_araddr_o, 32'h0000_4000);
        tick();
        checkOutput("bp_rready_low", m_axil_rready_o, 0);
        m_axil_rdata_i  = 32'h4444_0000;
        m_axil_rvalid_i = 1'b1;
        tick();
        tick();
        tick();
        checkOutput("bp_rready_still_low", m_axil_rready_o, 0);
        checkOutput("bp_head_word", stream_data_o, 32'h3333_0000);
        base = pop_cnt;
        stream_yumi_i = 1'b1;
        waitFor(2, "bp_rready0", 20);
        tick();
        m_axil_rvalid_i = 1'b0;
        waitFor(1, "bp_arvalid1", 20);
        checkOutput("bp_araddr1", m_axil_araddr_o, 32'h0000_4004);
        tick();
        m_axil_rdata_i  = 32'h4444_0004;
        m_axil_rvalid_i = 1'b1;
        waitFor(2, "bp_rready1", 20);
        tick();
        m_axil_rvalid_i = 1'b0;
        waitFor(3, "bp_drain", 20);
        stream_yumi_i = 1'b0;
        checkOutput("bp_pop_count", pop_cnt - base, 4);
        checkOutput("bp_word0", pop_log[base], 32'h3333_0000);
        checkOutput("bp_word1", pop_log[base + 1], 32'h3333_0004);
        checkOutput("bp_word2", pop_log[base + 2], 32'h4444_0000);
        checkOutput("bp_word3", pop_log[base + 3], 32'h4444_0004);
        checkOutput("bp_ar_count", ar_cnt - ar_start, 4);
        checkOutput("err_sticky_read", error_o, 1);

        $display("[TB] async reset mid-read");
        applyStimulus(32'h8000_7000);
        applyStimulus(32'h0000_0000);
        tick();
        m_axil_rdata_i  = 32'h7777_0000;
        m_axil_rvalid_i = 1'b1;
        tick();
        m_axil_rvalid_i = 1'b0;
        tick();
        checkOutput("mid_rready", m_axil_rready_o, 1);
        checkOutput("mid_stream_v", stream_v_o, 1);
        #3 reset_n_i = 1'b0;
        #1;
        checkOutput("arst_stream_v", stream_v_o, 0);
        checkOutput("arst_rready", m_axil_rready_o, 0);
        checkOutput("arst_arvalid", m_axil_arvalid_o, 0);
        checkOutput("arst_stream_ready", stream_ready_o, 0);
        checkOutput("arst_error", error_o, 0);
        #3 reset_n_i = 1'b1;
        tick();
        b_start = b_cnt;
        applyStimulus(32'h0000_9000);
        applyStimulus(32'h0000_00CD);
        checkOutput("post_awaddr", m_axil_awaddr_o, 32'h0000_9000);
        checkOutput("post_wdata", m_axil_wdata_o, 32'h0000_00CD);
        tick();
        m_axil_bvalid_i = 1'b1;
        tick();
        m_axil_bvalid_i = 1'b0;
        checkOutput("post_b_count", b_cnt - b_start, 1);
        checkOutput("post_ready", stream_ready_o, 1);
        checkOutput("post_no_stream_v", stream_v_o, 0);
        checkOutput("post_error", error_o, 0);

`ifdef BP_STREAM_HOST_AXIL_TIMEOUT_EN
        $display("[TB] read timeout");
        ar_start = ar_cnt;
        base     = pop_cnt;
        stream_yumi_i = 1'b1;
        applyStimulus(32'h8000_A000);
        applyStimulus(32'h0000_0000);
        tick();
        tick();
        waitFor(0, "tmo_return", 2200);
        waitFor(3, "tmo_drain", 20);
        stream_yumi_i = 1'b0;
        checkOutput("tmo_error", error_o, 1);
        checkOutput("tmo_pop_count", pop_cnt - base, 2);
        checkOutput("tmo_word0", pop_log[base], 32'hDEAD_BEEF);
        checkOutput("tmo_word1", pop_log[base + 1], 32'hDEAD_BEEF);
        checkOutput("tmo_ar_count", ar_cnt - ar_start, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
